// File: rtl/regfile_port_arbiter_pkg.sv
// risc16_arb_pkg: shared sizes, state type and write-enable decode for the register-file port arbiter
package risc16_arb_pkg;
  localparam int NUM_REQ = 8;
  localparam int IDX_W = 3;
  localparam int HOLD_W = 8;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  function automatic logic [NUM_REQ-1:0] dec3to8(input logic [IDX_W-1:0] idx, input logic en);
    return en ? NUM_REQ'(1) << idx : '0;
  endfunction
endpackage

// File: rtl/regfile_port_arbiter_if.sv
// regfile_port_arbiter_if: request/grant bundle between requesters and the write-port arbiter
interface regfile_port_arbiter_if;
  import risc16_arb_pkg::*;
  logic [NUM_REQ-1:0] req;
  logic [IDX_W-1:0] grant_idx;
  logic grant_en;
  logic [NUM_REQ-1:0] grant;
  logic revoked;
  modport master (output req, input grant_idx, grant_en, grant, revoked);
  modport slave (input req, output grant_idx, grant_en, grant, revoked);
endinterface

// File: rtl/regfile_port_arbiter_rr_pick8.sv
// rr_pick8: first set request at or after ptr, wrapping 7->0 (rotate, priority-encode, un-rotate)
module rr_pick8
  import risc16_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0] w_rot;
  logic [IDX_W-1:0] w_pos;
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[NUM_REQ-1:0];
  always_comb begin
    w_pos = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (w_rot[i]) w_pos = IDX_W'(i);
  end
  assign o_idx = w_pos + i_ptr;
  assign o_valid = |i_req;
endmodule

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: round-robin owner of the register-file write port with a hold-time limit
module regfile_port_arbiter
  import risc16_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input logic clk,
  input logic rst,
  regfile_port_arbiter_if.slave bus
);
  arb_state_t r_state, w_state_n;
  logic [IDX_W-1:0] r_ptr, w_ptr_n, r_owner, w_owner_n, w_pick_idx;
  logic [HOLD_W-1:0] r_hold, w_hold_n;
  logic r_en, w_en_n, r_rev, w_rev_n, w_pick_valid, w_limit;
  rr_pick8 u_pick (
    .i_req  (bus.req),
    .i_ptr  (r_ptr),
    .o_idx  (w_pick_idx),
    .o_valid(w_pick_valid)
  );
  assign w_limit = (MAX_HOLD != 0) && (r_hold == HOLD_W'(MAX_HOLD));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_owner <= '0;
      r_hold <= '0;
      r_en <= 1'b0;
      r_rev <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ptr <= w_ptr_n;
      r_owner <= w_owner_n;
      r_hold <= w_hold_n;
      r_en <= w_en_n;
      r_rev <= w_rev_n;
    end
  end
  // Every ownership change passes through IDLE, leaving a gap cycle on the decoder enable
  always_comb begin
    w_state_n = r_state;
    w_ptr_n = r_ptr;
    w_owner_n = r_owner;
    w_hold_n = r_hold;
    w_en_n = r_en;
    w_rev_n = 1'b0;
    case (r_state)
      IDLE: begin
        w_en_n = w_pick_valid;
        if (w_pick_valid) begin
          w_owner_n = w_pick_idx;
          w_hold_n = HOLD_W'(1);
          w_state_n = GRANT;
        end
      end
      GRANT: begin
        if (!bus.req[r_owner] || w_limit) begin
          w_en_n = 1'b0;
          w_rev_n = bus.req[r_owner];
          w_ptr_n = r_owner + 1'b1;
          w_state_n = IDLE;
        end else begin
          w_hold_n = (r_hold == '1) ? r_hold : r_hold + 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end
  assign bus.grant_idx = r_owner;
  assign bus.grant_en = r_en;
  assign bus.revoked = r_rev;
  assign bus.grant = dec3to8(r_owner, r_en);
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: directed checks of a MAX_HOLD=4 arbiter and a default (16) arbiter on shared requests
module tb_regfile_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int passed = 0;
  int failed = 0;
  logic [7:0] rr_req;
  logic [2:0] rr_exp [4] = '{3'd2, 3'd5, 3'd7, 3'd2};
  regfile_port_arbiter_if if4 ();
  regfile_port_arbiter_if if16 ();
  assign if16.req = if4.req;
  regfile_port_arbiter #(.MAX_HOLD(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
  regfile_port_arbiter u16 (.clk(clk), .rst(rst), .bus(if16.slave));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk4(input string tag, input logic en, input logic [2:0] idx, input logic rev);
    chk({tag, "_en"}, {7'd0, if4.grant_en}, {7'd0, en});
    chk({tag, "_idx"}, {5'd0, if4.grant_idx}, {5'd0, idx});
    chk({tag, "_grant"}, if4.grant, en ? 8'd1 << idx : 8'd0);
    chk({tag, "_rev"}, {7'd0, if4.revoked}, {7'd0, rev});
  endtask
  initial begin
    rst = 1'b1;
    if4.req = 8'hFF;
    step();
    step();
    chk4("reset", 1'b0, 3'd0, 1'b0);
    chk4("reset16", if16.grant_en, if16.grant_idx, if16.revoked);
    chk("reset16_en", {7'd0, if16.grant_en}, 8'd0);
    rst = 1'b0;
    step();
    chk4("first_grant", 1'b1, 3'd0, 1'b0);
    if4.req = 8'h00;
    step();
    chk4("first_release", 1'b0, 3'd0, 1'b0);
    rr_req = 8'b1010_0100;
    if4.req = rr_req;
    for (int k = 0; k < 4; k++) begin
      step();
      chk4($sformatf("rr%0d_grant", k), 1'b1, rr_exp[k], 1'b0);
      step();
      step();
      chk4($sformatf("rr%0d_hold", k), 1'b1, rr_exp[k], 1'b0);
      if4.req = rr_req & ~(8'd1 << rr_exp[k]);
      step();
      chk4($sformatf("rr%0d_gap", k), 1'b0, rr_exp[k], 1'b0);
      if4.req = rr_req;
    end
    if4.req = 8'h40;
    step();
    chk4("own6", 1'b1, 3'd6, 1'b0);
    if4.req = 8'h03;
    step();
    chk4("own6_release", 1'b0, 3'd6, 1'b0);
    step();
    chk4("wrap0", 1'b1, 3'd0, 1'b0);
    if4.req = 8'h02;
    step();
    chk4("wrap0_release", 1'b0, 3'd0, 1'b0);
    step();
    chk4("wrap1", 1'b1, 3'd1, 1'b0);
    if4.req = 8'h08;
    step();
    chk4("pre_revoke_gap", 1'b0, 3'd1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk4($sformatf("hold4_c%0d", k), 1'b1, 3'd3, 1'b0);
    end
    step();
    chk4("revoke", 1'b0, 3'd3, 1'b1);
    chk("hold16_no_revoke", {6'd0, if16.grant_en, if16.revoked}, 8'b10);
    step();
    chk4("regrant3", 1'b1, 3'd3, 1'b0);
    step();
    step();
    step();
    chk4("limit_c4", 1'b1, 3'd3, 1'b0);
    if4.req = 8'h00;
    step();
    chk4("release_at_limit", 1'b0, 3'd3, 1'b0);
    if4.req = 8'h20;
    step();
    chk4("own5", 1'b1, 3'd5, 1'b0);
    step();
    rst = 1'b1;
    step();
    chk4("mid_reset", 1'b0, 3'd0, 1'b0);
    rst = 1'b0;
    if4.req = 8'b0010_0001;
    step();
    chk4("ptr_reset", 1'b1, 3'd0, 1'b0);
    if4.req = 8'h00;
    step();
    if4.req = 8'h10;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("d16_c%0d", k), {5'd0, if16.grant_idx}, 8'd4);
      chk($sformatf("d16_en%0d", k), {6'd0, if16.grant_en, if16.revoked}, 8'b10);
    end
    step();
    chk("d16_revoke", {6'd0, if16.grant_en, if16.revoked}, 8'b01);
    step();
    chk("d16_regrant", if16.grant, 8'h10);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Round-robin arbiter that shares the single register-file write port among eight requesters in the RISC16 datapath. It owns the `din[2:0]`/`en` inputs of the 3-to-8 write-enable decoder. It grants one requester at a time and holds the grant until that requester releases. A hold-time limit forces release so no requester can starve the others.

## Interface
Parameters:
- `MAX_HOLD`, 16: maximum consecutive granted cycles per owner before forced revoke. 0 disables the limit. Legal range 0..255.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  8  request vector; bit i high means requester i wants the write port.
- `grant_idx`  out  3  index of the current or most recent owner; drives decoder `din`.
- `grant_en`  out  1  grant valid; drives decoder `en`.
- `grant`  out  8  one-hot grant, equal to `grant_en ? (1 << grant_idx) : 0`.
- `revoked`  out  1  one-cycle pulse when the grant is removed by the `MAX_HOLD` limit.

## Operation
- State is held in registers `state` (IDLE or GRANT), `ptr[2:0]` (round-robin start index), `owner[2:0]` (drives `grant_idx`) and `hold_cnt[7:0]`.
- **Reset values:** `state`=IDLE, `ptr`=0, `grant_idx`=0, `grant_en`=0, `grant`=0, `revoked`=0, `hold_cnt`=0.
- **IDLE:**
  - If `req`=0, stay in IDLE. Outputs keep their values except that `grant_en`=0 and `revoked`=0.
  - If `req`≠0, pick the first set bit scanning ptr, ptr+1, …, wrapping 7→0.
  - Load `owner` with that index, set `grant_en`=1 and `hold_cnt`=1, then go to GRANT.
- **GRANT, normal release:** if `req[owner]`=0, set `grant_en`=0 and `ptr`=owner+1 (mod 8), then go to IDLE.
- **GRANT, forced revoke:** if `req[owner]`=1, `MAX_HOLD`≠0 and `hold_cnt`=`MAX_HOLD`, set `grant_en`=0, pulse `revoked`=1, set `ptr`=owner+1 (mod 8), then go to IDLE.
- **GRANT, otherwise:** stay in GRANT and increment `hold_cnt`. The counter saturates at 255 when `MAX_HOLD`=0.
- Requests from non-owners never preempt the current owner.
- A revoked requester that keeps `req` high re-enters arbitration, where it now has the lowest priority.
- `grant_idx` keeps the last owner while `grant_en`=0.
- Ownership always changes through IDLE, so there is at least one cycle with `grant_en`=0 between consecutive owners. This prevents two decoder outputs from being active in adjacent cycles with no gap.

## Timing
- **Grant latency:** `req` sampled nonzero at edge t in IDLE gives `grant_en`=1 after edge t. Latency is 1 cycle.
- **Release:** owner `req` sampled low at edge t gives `grant_en`=0 after edge t.
  - The next owner is granted after edge t+1.
  - Owner-to-owner turnaround is 2 cycles.
- **Revoke:** with `MAX_HOLD`=N, `grant_en` is high for exactly N cycles.
  - `revoked` goes high for 1 cycle, coinciding with the first `grant_en`=0 cycle.
- **Same-edge events:**
  - Owner release and a new request at the same edge: the release wins, and the new request is arbitrated at the next edge.
  - Owner release at the same edge as the limit being reached: treated as a normal release, so `revoked` stays 0.
- **Reset mid-grant:** `rst` high at edge t gives all outputs at their reset values after edge t, with no `revoked` pulse. `ptr` returns to 0.
- All outputs are registered except `grant`, which is a pure decode of the `grant_en`/`grant_idx` registers.

## Structure
- Shared package `risc16_arb_pkg` holds:
  - `NUM_REQ`=8 and `IDX_W`=3;
  - the `arb_state_t` enum (IDLE, GRANT);
  - the constant `HOLD_W`=8.
- Sub-module `rr_pick8` is combinational. It takes `req[7:0]` and `ptr[2:0]` and produces `idx[2:0]` and `valid`, implemented as a rotate, priority-encode and un-rotate.
- The top level holds the FSM, counters and output registers. `grant` reuses the existing 3-to-8 decoder logic.

## Test plan
- **Reset and idle:** assert `rst` for 2 cycles with `req`=8'hFF → `grant_en`=0, `grant`=0, `revoked`=0. Release `rst` → `grant_idx`=0 and `grant`=8'h01 one cycle later.
- **Round-robin order:** hold `req`=8'b1010_0100, each owner holding for 3 cycles → grant order 2, 5, 7, 2, with exactly 1 idle cycle between owners.
- **Wrap-around:** after owner 6 releases, with `req`=8'b0000_0011 → the next grant is index 0, then index 1.
- **Forced revoke:** `MAX_HOLD`=4, `req`=8'h08 held high → `grant`=8'h08 for 4 cycles, then 1 cycle with `revoked`=1 and `grant_en`=0, then regrant of index 3.
- **Release at the limit:** `MAX_HOLD`=4, owner drops `req` in its 4th grant cycle → `grant_en` falls and `revoked` stays 0.
- **Reset mid-grant:** pulse `rst` while index 5 is granted → `grant_en`=0 after the edge. With `req`=8'b0010_0001 afterwards, `ptr` is back at 0 → index 0 is granted first.
